// File: rtl/tank_key_control_pkg.sv
// Shared types, key codes and direction helpers for the tank keyboard front end.
// The file name follows the block, the package keeps the battle_pkg name used across the game.
package battle_pkg;

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_t;

   localparam logic [8:0] KEY_UP_CODE    = 9'h175;
   localparam logic [8:0] KEY_DOWN_CODE  = 9'h172;
   localparam logic [8:0] KEY_LEFT_CODE  = 9'h16B;
   localparam logic [8:0] KEY_RIGHT_CODE = 9'h174;
   localparam logic [8:0] KEY_FIRE_CODE  = 9'h029;

   // Bit order matches the movement stage: 0=down, 1=up, 2=left, 3=right.
   function automatic logic [3:0] dir_to_onehot(dir_t dir);
      logic [3:0] bits;
      bits = 4'b0000;
      case (dir)
         DIR_DOWN:  bits = 4'b0001;
         DIR_UP:    bits = 4'b0010;
         DIR_LEFT:  bits = 4'b0100;
         DIR_RIGHT: bits = 4'b1000;
         default:   bits = 4'b0000;
      endcase
      return bits;
   endfunction

   function automatic logic [1:0] dir_to_facing(dir_t dir);
      logic [1:0] code;
      code = 2'd0;
      case (dir)
         DIR_UP:    code = 2'd0;
         DIR_DOWN:  code = 2'd1;
         DIR_LEFT:  code = 2'd2;
         DIR_RIGHT: code = 2'd3;
         default:   code = 2'd0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/tank_key_control_if.sv
// Keyboard event bundle between the keyboard decoder (master) and the tank key control (slave).
interface tank_key_control_if;
   logic [8:0] keyCode;
   logic       make;
   logic       brakee;
   logic       startOfFrame;
   logic       collision;
   logic [3:0] inputKeyPressed;
   logic [1:0] facing;
   logic       firePulse;

   modport master (
      output keyCode, make, brakee, startOfFrame, collision,
      input  inputKeyPressed, facing, firePulse
   );

   modport slave (
      input  keyCode, make, brakee, startOfFrame, collision,
      output inputKeyPressed, facing, firePulse
   );
endinterface

// File: rtl/tank_key_control_fire_cooldown.sv
// Rate limiter for the fire key: one shot, then a frame-counted cooldown during which
// further requests are dropped rather than queued.
module fire_cooldown #(
   parameter int COOLDOWN_FRAMES = 15
) (
   input  logic clk,
   input  logic resetN,
   input  logic startOfFrame,
   input  logic fireReq,
   output logic firePulse
);

   localparam logic [7:0] RELOAD = 8'(COOLDOWN_FRAMES);

   logic [7:0] count_q;
   logic       shoot;

   // A request landing on the frame tick that empties the counter still sees it nonzero and is dropped.
   assign shoot = fireReq && (count_q == 8'd0);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         count_q   <= 8'd0;
         firePulse <= 1'b0;
      end else begin
         firePulse <= shoot;
         if (shoot) begin
            count_q <= RELOAD;
         end else if (startOfFrame && (count_q != 8'd0)) begin
            count_q <= count_q - 8'd1;
         end
      end
   end

endmodule

// File: rtl/tank_key_control.sv
// Turns arrow make/break events into a one-hot direction, a facing code and a rate-limited fire pulse.
// Optional feature macro: COLLISION_BLOCK_EN masks the direction the tank just collided in.
module tank_key_control
   import battle_pkg::*;
#(
   parameter logic [8:0] KEY_UP               = KEY_UP_CODE,
   parameter logic [8:0] KEY_DOWN             = KEY_DOWN_CODE,
   parameter logic [8:0] KEY_LEFT             = KEY_LEFT_CODE,
   parameter logic [8:0] KEY_RIGHT            = KEY_RIGHT_CODE,
   parameter logic [8:0] KEY_FIRE             = KEY_FIRE_CODE,
   parameter int         FIRE_COOLDOWN_FRAMES = 15
) (
   input logic              clk,
   input logic              resetN,
   tank_key_control_if.slave kb
);

   logic       ev_make;
   logic       ev_brk;
   dir_t       key_dir;
   logic [3:0] key_mask;
   logic [3:0] held_q;
   logic [3:0] held_d;
   dir_t       state_q;
   dir_t       state_d;
   logic [3:0] block_mask;
   logic [3:0] dir_q;
   logic [1:0] facing_q;
   logic       fire_pulse;

   // Simultaneous make and break on one clock is treated as noise.
   assign ev_make  = kb.make && !kb.brakee;
   assign ev_brk   = kb.brakee && !kb.make;
   assign key_mask = dir_to_onehot(key_dir);

   always_comb begin
      key_dir = DIR_NONE;
      if (kb.keyCode == KEY_UP) begin
         key_dir = DIR_UP;
      end else if (kb.keyCode == KEY_DOWN) begin
         key_dir = DIR_DOWN;
      end else if (kb.keyCode == KEY_LEFT) begin
         key_dir = DIR_LEFT;
      end else if (kb.keyCode == KEY_RIGHT) begin
         key_dir = DIR_RIGHT;
      end
   end

   // Latest press wins; releasing the active key falls back to a held key by fixed priority.
   always_comb begin
      held_d  = held_q;
      state_d = state_q;
      if (ev_make && (key_dir != DIR_NONE)) begin
         held_d  = held_q | key_mask;
         state_d = key_dir;
      end else if (ev_brk && (key_dir != DIR_NONE)) begin
         held_d = held_q & ~key_mask;
         if (key_dir == state_q) begin
            if (held_d[1]) begin
               state_d = DIR_UP;
            end else if (held_d[0]) begin
               state_d = DIR_DOWN;
            end else if (held_d[2]) begin
               state_d = DIR_LEFT;
            end else if (held_d[3]) begin
               state_d = DIR_RIGHT;
            end else begin
               state_d = DIR_NONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         held_q  <= 4'b0000;
         state_q <= DIR_NONE;
      end else begin
         held_q  <= held_d;
         state_q <= state_d;
      end
   end

`ifdef COLLISION_BLOCK_EN
   dir_t blocked_q;
   dir_t blocked_d;

   // A block only survives while the same direction stays active and its key stays down.
   always_comb begin
      blocked_d = blocked_q;
      if (state_d != state_q) begin
         blocked_d = DIR_NONE;
      end
      if (ev_brk && (key_dir != DIR_NONE) && (key_dir == blocked_q)) begin
         blocked_d = DIR_NONE;
      end
      if (kb.collision && (state_q != DIR_NONE) && (state_d == state_q)) begin
         blocked_d = state_q;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         blocked_q <= DIR_NONE;
      end else begin
         blocked_q <= blocked_d;
      end
   end

   assign block_mask = dir_to_onehot(blocked_d);
`else
   logic unused_collision;
   assign unused_collision = kb.collision;
   assign block_mask       = 4'b0000;
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         dir_q    <= 4'b0000;
         facing_q <= 2'd0;
      end else begin
         dir_q <= dir_to_onehot(state_d) & ~block_mask;
         if (state_d != DIR_NONE) begin
            facing_q <= dir_to_facing(state_d);
         end
      end
   end

   fire_cooldown #(
      .COOLDOWN_FRAMES(FIRE_COOLDOWN_FRAMES)
   ) u_fire (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (kb.startOfFrame),
      .fireReq      (ev_make && (kb.keyCode == KEY_FIRE)),
      .firePulse    (fire_pulse)
   );

   assign kb.inputKeyPressed = dir_q;
   assign kb.facing          = facing_q;
   assign kb.firePulse       = fire_pulse;

endmodule

// File: tb/tb_tank_key_control.sv
// Scoreboard bench for tank_key_control: a behavioural key model predicts every clock's outputs
// while a monitor compares them; directed scenarios come first, then randomized traffic.
module tb_tank_key_control;

   typedef struct packed {
      logic [3:0] ipk;
      logic [1:0] fac;
      logic       fire;
   } exp_t;

   logic clk = 1'b0;
   logic resetN;
   tank_key_control_if kbIf();

   tank_key_control dut (
      .clk    (clk),
      .resetN (resetN),
      .kb     (kbIf)
   );

   always #5 clk = ~clk;

   exp_t expQ[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state: directions numbered 1=up 2=down 3=left 4=right, 0=none.
   int mActive  = 0;
   bit mHeld[5];
   int mFacing  = 0;
   int mCool    = 0;
   int mBlocked = 0;

   function automatic int decodeKey(logic [8:0] kc);
      case (kc)
         9'h175:  return 1;
         9'h172:  return 2;
         9'h16B:  return 3;
         9'h174:  return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [3:0] dirBits(int d);
      case (d)
         1:       return 4'b0010;
         2:       return 4'b0001;
         3:       return 4'b0100;
         4:       return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic checkOutput(string name, logic [7:0] actual, logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelStep(bit rstN, logic [8:0] kc, bit mk, bit br, bit sof, bit col);
      exp_t e;
      int   d;
      int   prev;
      bit   mEv;
      bit   bEv;
      bit   fire;
      fire = 1'b0;
      if (!rstN) begin
         mActive  = 0;
         mFacing  = 0;
         mCool    = 0;
         mBlocked = 0;
         for (int i = 0; i < 5; i++) mHeld[i] = 1'b0;
      end else begin
         mEv  = mk && !br;
         bEv  = br && !mk;
         d    = decodeKey(kc);
         prev = mActive;
         fire = mEv && (kc == 9'h029) && (mCool == 0);
         if (fire) mCool = 15;
         else if (sof && mCool > 0) mCool = mCool - 1;
         if (mEv && d != 0) begin
            mHeld[d] = 1'b1;
            mActive  = d;
         end else if (bEv && d != 0) begin
            mHeld[d] = 1'b0;
            if (d == mActive) begin
               mActive = 0;
               for (int k = 4; k >= 1; k--) if (mHeld[k]) mActive = k;
            end
         end
`ifdef COLLISION_BLOCK_EN
         if (mActive != prev) mBlocked = 0;
         if (bEv && d != 0 && d == mBlocked) mBlocked = 0;
         if (col && prev != 0 && mActive == prev) mBlocked = prev;
`endif
         if (mActive != 0) mFacing = mActive - 1;
      end
      e.ipk  = dirBits(mActive) & ~dirBits(mBlocked);
      e.fac  = 2'(mFacing);
      e.fire = fire;
      expQ.push_back(e);
   endtask

   // One call is one clock: inputs change on the falling edge, the model predicts the next rising edge.
   task automatic applyStimulus(bit rstN, logic [8:0] kc, bit mk, bit br, bit sof, bit col);
      @(negedge clk);
      resetN             = rstN;
      kbIf.keyCode       = kc;
      kbIf.make          = mk;
      kbIf.brakee        = br;
      kbIf.startOfFrame  = sof;
      kbIf.collision     = col;
      modelStep(rstN, kc, mk, br, sof, col);
   endtask

   task automatic checkNow(string name, logic [3:0] ipk, logic [1:0] fac, bit fire);
      @(posedge clk);
      #2;
      checkOutput({name, ".dir"}, 8'(kbIf.inputKeyPressed), 8'(ipk));
      checkOutput({name, ".facing"}, 8'(kbIf.facing), 8'(fac));
      checkOutput({name, ".fire"}, 8'(kbIf.firePulse), 8'(fire));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("sb.dir", 8'(kbIf.inputKeyPressed), 8'(e.ipk));
            checkOutput("sb.facing", 8'(kbIf.facing), 8'(e.fac));
            checkOutput("sb.fire", 8'(kbIf.firePulse), 8'(e.fire));
         end
      end
   end

   initial begin : stimulus
      logic [8:0] kc;
      logic [8:0] codes[8];
      codes[0] = 9'h175; codes[1] = 9'h172; codes[2] = 9'h16B; codes[3] = 9'h174;
      codes[4] = 9'h029; codes[5] = 9'h029; codes[6] = 9'h075; codes[7] = 9'h000;
      resetN             = 1'b0;
      kbIf.keyCode       = 9'h000;
      kbIf.make          = 1'b0;
      kbIf.brakee        = 1'b0;
      kbIf.startOfFrame  = 1'b0;
      kbIf.collision     = 1'b0;

      applyStimulus(0, 9'h000, 0, 0, 0, 0);
      checkNow("reset", 4'b0000, 2'd0, 0);

      // Arrow priority and release fallback
      applyStimulus(1, 9'h175, 1, 0, 0, 0); checkNow("makeUp", 4'b0010, 2'd0, 0);
      applyStimulus(1, 9'h16B, 1, 0, 0, 0); checkNow("makeLeft", 4'b0100, 2'd2, 0);
      applyStimulus(1, 9'h16B, 0, 1, 0, 0); checkNow("brkLeft", 4'b0010, 2'd0, 0);
      applyStimulus(1, 9'h175, 0, 1, 0, 0); checkNow("brkUp", 4'b0000, 2'd0, 0);
      applyStimulus(1, 9'h172, 1, 0, 0, 0); checkNow("makeDown", 4'b0001, 2'd1, 0);
      applyStimulus(1, 9'h174, 1, 0, 0, 0); checkNow("makeRight", 4'b1000, 2'd3, 0);
      applyStimulus(1, 9'h174, 0, 1, 0, 0); checkNow("brkRight", 4'b0001, 2'd1, 0);
      applyStimulus(1, 9'h175, 1, 1, 0, 0); checkNow("makeBrkSame", 4'b0001, 2'd1, 0);
      applyStimulus(1, 9'h172, 0, 1, 0, 0); checkNow("facingHolds", 4'b0000, 2'd1, 0);

      // Fire cooldown, including the tick-and-request collision on the last frame
      applyStimulus(1, 9'h029, 1, 0, 0, 0); checkNow("fire1", 4'b0000, 2'd1, 1);
      applyStimulus(1, 9'h000, 0, 0, 0, 0); checkNow("fireOneClk", 4'b0000, 2'd1, 0);
      for (int f = 1; f <= 14; f++) begin
         applyStimulus(1, 9'h000, 0, 0, 1, 0);
         applyStimulus(1, 9'h029, 1, 0, 0, 0);
      end
      applyStimulus(1, 9'h029, 1, 0, 1, 0); checkNow("fireOnLastTick", 4'b0000, 2'd1, 0);
      applyStimulus(1, 9'h029, 1, 0, 0, 0); checkNow("fire2", 4'b0000, 2'd1, 1);
      applyStimulus(1, 9'h029, 0, 1, 0, 0); checkNow("fireBrk", 4'b0000, 2'd1, 0);

      // Collision blocking
      applyStimulus(1, 9'h174, 1, 0, 0, 0); checkNow("holdRight", 4'b1000, 2'd3, 0);
`ifdef COLLISION_BLOCK_EN
      applyStimulus(1, 9'h000, 0, 0, 0, 1); checkNow("collide", 4'b0000, 2'd3, 0);
      applyStimulus(1, 9'h174, 1, 0, 0, 0); checkNow("rePressBlocked", 4'b0000, 2'd3, 0);
`else
      applyStimulus(1, 9'h000, 0, 0, 0, 1); checkNow("collideIgnored", 4'b1000, 2'd3, 0);
      applyStimulus(1, 9'h174, 1, 0, 0, 0); checkNow("rePress", 4'b1000, 2'd3, 0);
`endif
      applyStimulus(1, 9'h16B, 1, 0, 0, 0); checkNow("makeLeftAfter", 4'b0100, 2'd2, 0);
      applyStimulus(1, 9'h16B, 0, 1, 0, 0); checkNow("backToRight", 4'b1000, 2'd3, 0);
      applyStimulus(1, 9'h174, 0, 1, 0, 0); checkNow("allReleased", 4'b0000, 2'd3, 0);

      // Reset in the middle of a hold wipes the held keys
      applyStimulus(1, 9'h175, 1, 0, 0, 0);
      applyStimulus(1, 9'h174, 1, 0, 0, 0); checkNow("holdUpRight", 4'b1000, 2'd3, 0);
      applyStimulus(0, 9'h000, 0, 0, 0, 0); checkNow("midReset", 4'b0000, 2'd0, 0);
      applyStimulus(1, 9'h174, 0, 1, 0, 0); checkNow("noHeldAfterReset", 4'b0000, 2'd0, 0);
      applyStimulus(1, 9'h175, 1, 0, 0, 0); checkNow("newMake", 4'b0010, 2'd0, 0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         kc = codes[$urandom_range(0, 7)];
         if (kc == 9'h000) kc = 9'($urandom);
         applyStimulus(($urandom_range(0, 499) != 0), kc,
                       ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      end

      applyStimulus(1, 9'h000, 0, 0, 0, 0);
      @(posedge clk);
      #3;
      checkOutput("queueDrained", 8'(expQ.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
